mult_div_unit: RTL and testbench

// - Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU; sits beside the ALU in the CPU datapath.
// - Takes rs/rt register data and produces the 64-bit HI/LO result that the HI/LO register file latches.
// - Multi-cycle, one operation in flight; busy is used by the decoder to stall MFHI/MFLO and further mult/div ops.

---
 rtl/mult_div_unit.sv | 155 +++++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit producing the 64-bit HI/LO result for MULT, MULTU, DIV and DIVU.
// One operation in flight: WIDTH shift-add/restoring steps on magnitudes, then one sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    counter;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] hi_work;
  logic [WIDTH-1:0] lo_work;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] hi_fix, lo_fix;
  logic             dz_fix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (clk_enable) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (counter == LAST_STEP) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Signed ops work on magnitudes; unsigned ops take the operands as-is.
  always_comb begin
    a_neg = ~op[0] & operand_a[WIDTH-1];
    b_neg = ~op[0] & operand_b[WIDTH-1];
    a_abs = a_neg ? (~operand_a + 1'b1) : operand_a;
    b_abs = b_neg ? (~operand_b + 1'b1) : operand_b;
  end

  // One iteration: multiply keeps {partial, multiplier} shifting right;
  // divide keeps {remainder, dividend/quotient} shifting left.
  always_comb begin
    mul_sum   = {1'b0, hi_work} + (lo_work[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});
    div_shift = {hi_work, lo_work[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - b_mag;
    hi_step   = mul_sum[WIDTH:1];
    lo_step   = {mul_sum[0], lo_work[WIDTH-1:1]};
    if (is_div) begin
      if (div_shift >= {1'b0, b_mag}) begin
        hi_step = div_diff;
        lo_step = {lo_work[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = div_shift[WIDTH-1:0];
        lo_step = {lo_work[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Divide by zero bypasses the iterated result and reports the raw dividend.
  always_comb begin
    prod_fix = neg_q ? (~{hi_work, lo_work} + 1'b1) : {hi_work, lo_work};
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    dz_fix   = 1'b0;
    if (is_div) begin
      if (b_mag == '0) begin
        hi_fix = a_raw;
        lo_fix = '1;
        dz_fix = 1'b1;
      end else begin
        hi_fix = neg_r ? (~hi_work + 1'b1) : hi_work;
        lo_fix = neg_q ? (~lo_work + 1'b1) : lo_work;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter     <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      a_raw       <= '0;
      b_mag       <= '0;
      hi_work     <= '0;
      lo_work     <= '0;
      hi_out      <= '0;
      lo_out      <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else if (clk_enable) begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            a_raw   <= operand_a;
            b_mag   <= b_abs;
            hi_work <= '0;
            lo_work <= a_abs;
            counter <= '0;
          end
        end
        CALC: begin
          hi_work <= hi_step;
          lo_work <= lo_step;
          counter <= counter + 1'b1;
        end
        FIX: begin
          hi_out      <= hi_fix;
          lo_out      <= lo_fix;
          div_by_zero <= dz_fix;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: hand-computed HI/LO results, latency,
// clock-enable stalls, ignored starts while busy and asynchronous reset mid-operation.
module tb_mult_div_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .clk_enable(clk_enable),
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy(busy),
    .done(done),
    .hi_out(hi_out),
    .lo_out(lo_out),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Pulse start for one edge; operands are scrambled afterwards to prove they were sampled.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o;
    operand_a = a;
    operand_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o;
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic waitDone(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 200);
    if (!done) checkOutput("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
    int edges;
    applyStimulus(o, a, b);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    waitDone(edges);
    checkOutput({tag, "_latency"}, 64'(edges), 64'd33);
    checkOutput({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    checkOutput({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
    checkOutput({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
    checkOutput({tag, "_dz"}, 64'(div_by_zero), 64'(exp_dz));
  endtask

  initial begin
    int edges;
    int total;
    logic seen_done;

    reset = 1'b1;
    clk_enable = 1'b1;
    start = 1'b0;
    op = MULT;
    operand_a = '0;
    operand_b = '0;
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hilo", {hi_out, lo_out}, 64'd0);
    checkOutput("reset_dz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    runOp("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", 64'(done), 64'd0);
    runOp("mult_neg", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    runOp("mult_minmin", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    runOp("div_neg_dividend", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runOp("div_neg_divisor", DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    runOp("divu_small", DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
    runOp("div_overflow", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    runOp("divu_zero", DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1);
    runOp("div_zero_signed", DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    runOp("multu_after_dz", MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

    // Stall 5 cycles mid-CALC while a second start is held high.
    applyStimulus(DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    clk_enable = 1'b0;
    start = 1'b1;
    op = MULT;
    operand_a = 32'd11;
    operand_b = 32'd13;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("stall_busy", 64'(busy), 64'd1);
    checkOutput("stall_done", 64'(done), 64'd0);
    checkOutput("stall_hold", {hi_out, lo_out}, {32'd0, 32'd6});
    @(negedge clk);
    clk_enable = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(edges);
    total = 9 + 5 + 1 + edges;
    checkOutput("stall_latency", 64'(total), 64'd38);
    checkOutput("stall_hi", 64'(hi_out), 64'd2);
    checkOutput("stall_lo", 64'(lo_out), 64'd14);

    @(negedge clk);
    clk_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_hold_stalled", 64'(done), 64'd1);
    @(negedge clk);
    clk_enable = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("done_clear", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_queued_op", 64'(busy), 64'd0);
    checkOutput("no_queued_result", {hi_out, lo_out}, {32'd2, 32'd14});

    // Asynchronous reset between edges abandons the in-flight op.
    applyStimulus(MULTU, 32'd5, 32'd5);
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    checkOutput("midreset_hilo", {hi_out, lo_out}, 64'd0);
    #1;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    checkOutput("midreset_no_done", 64'(seen_done), 64'd0);
    runOp("after_reset", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
